// File: rtl/dmem_responder.sv
// dmem_responder: latency-configurable RV32 load/store responder over a word RAM
module dmem_responder #(
   parameter logic [31:0] BASE = 32'h8000_0000,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CLAST = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic st_q, cur_st, err, enter;
   logic [2:0] f3_q, cur_f3;
   logic [31:0] addr_q, wdata_q, cur_addr, cur_wdata, off, word, ld, wsh;
   logic [DEPTH_LOG2-1:0] idx;
   logic [1:0] lane;
   logic [7:0] b;
   logic [15:0] h;
   logic [3:0] mask;
   logic [31:0] mem [2**DEPTH_LOG2];
   assign req_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   // With LATENCY=1 the access happens on the accept edge, so decode straight from the request inputs
   always_comb begin
      cur_st = state == IDLE ? req_store : st_q;
      cur_f3 = state == IDLE ? req_funct3 : f3_q;
      cur_addr = state == IDLE ? req_addr : addr_q;
      cur_wdata = state == IDLE ? req_wdata : wdata_q;
      off = cur_addr - BASE;
      idx = off[DEPTH_LOG2+1:2];
      lane = off[1:0];
      word = mem[idx];
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      err = (off >> (DEPTH_LOG2 + 2)) != 0 || cur_f3[1:0] == 2'd3 ||
            (cur_f3[2] && (cur_st || cur_f3[1:0] == 2'd2)) ||
            (cur_f3[1:0] == 2'd1 && lane[0]) || (cur_f3[1:0] == 2'd2 && lane != 2'd0);
      ld = cur_f3[1:0] == 2'd0 ? {{24{b[7] & ~cur_f3[2]}}, b} :
           cur_f3[1:0] == 2'd1 ? {{16{h[15] & ~cur_f3[2]}}, h} : word;
      mask = cur_f3[1:0] == 2'd0 ? 4'b0001 << lane : cur_f3[1:0] == 2'd1 ? 4'b0011 << lane : 4'b1111;
      wsh = cur_wdata << {lane, 3'b000};
      enter = (state == IDLE && req_valid && LATENCY == 1) || (state == WAIT && cnt == CLAST);
      nxt = state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
            state == WAIT ? (cnt == CLAST ? RESP : WAIT) : (rsp_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= state == WAIT ? cnt + 1'b1 : '0;
         if (req_ready && req_valid) begin
            st_q <= req_store;
            f3_q <= req_funct3;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
         end
         if (enter) begin
            rsp_err <= err;
            rsp_rdata <= err || cur_st ? '0 : ld;
         end
      end
   always_ff @(posedge clk)
      if (!rst && enter && cur_st && !err)
         for (int i = 0; i < 4; i++)
            if (mask[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: LATENCY=2 and LATENCY=1 responders checked against a byte-array reference
module tb_dmem_responder;
   localparam logic [31:0] BASE = 32'h8000_0000;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst[2], req_valid[2], req_ready[2], req_store[2], rsp_valid[2], rsp_ready[2], rsp_err[2];
   logic [2:0] req_funct3[2];
   logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
   logic [7:0] ref_b[2][4096];
   int errors = 0, checks = 0;
   logic [31:0] rd;
   logic e;
   int lat;
   dmem_responder #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(2)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_store(req_store[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
   dmem_responder #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_store(req_store[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic void model(input int d, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic ex, output logic [31:0] rv);
      logic [31:0] off, v;
      int n;
      off = a - BASE;
      n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      ex = off >= 4096 || f3[1:0] == 2'd3 || (f3[2] && (st || f3[1:0] == 2'd2)) || (off % n) != 0;
      rv = '0;
      if (!ex) begin
         if (st) for (int i = 0; i < n; i++) ref_b[d][off + i] = wd[8*i +: 8];
         else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_b[d][off + i]) << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rv = v;
         end
      end
   endfunction
   // One full transaction; rsp_ready stays low for 'hold' RESP cycles while req_valid is pulsed
   task automatic txn(input int d, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] ord, output logic oe, output int olat);
      logic ee;
      logic [31:0] erd;
      int k;
      @(negedge clk);
      chk("req_ready_idle", req_ready[d], 1);
      req_valid[d] = 1; req_store[d] = st; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
      rsp_ready[d] = hold == 0;
      @(posedge clk);
      model(d, st, f3, a, wd, ee, erd);
      k = 0;
      @(negedge clk);
      req_valid[d] = 0;
      while (!rsp_valid[d] && k < 20) begin
         chk("req_ready_busy", req_ready[d], 0);
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      olat = k + 1;
      chk("rsp_valid", rsp_valid[d], 1);
      chk("latency", olat, d == 0 ? 2 : 1);
      ord = rsp_rdata[d];
      oe = rsp_err[d];
      chk("rdata_model", ord, erd);
      chk("err_model", oe, ee);
      for (int i = 0; i < hold; i++) begin
         req_valid[d] = i % 2 == 0;
         req_store[d] = 1'($urandom);
         req_addr[d] = BASE + ($urandom % 64);
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", rsp_valid[d], 1);
         chk("hold_rdata", rsp_rdata[d], ord);
         chk("hold_err", rsp_err[d], oe);
         chk("hold_req_ready", req_ready[d], 0);
      end
      req_valid[d] = 0;
      rsp_ready[d] = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rsp_done", rsp_valid[d], 0);
      chk("req_ready_after", req_ready[d], 1);
      rsp_ready[d] = 0;
   endtask
   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1; req_valid[d] = 0; req_store[d] = 0; req_funct3[d] = 0;
         req_addr[d] = 0; req_wdata[d] = 0; rsp_ready[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 0; rst[1] = 0;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", req_ready[d], 1);
         chk("rst_rsp_valid", rsp_valid[d], 0);
         chk("rst_rdata", rsp_rdata[d], 0);
         chk("rst_err", rsp_err[d], 0);
      end
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 16; w++) txn(d, 1, 3'b010, BASE + 32'(4 * w), $urandom, 0, rd, e, lat);
         txn(d, 1, 3'b010, BASE + 4, 32'hDEAD_BEEF, 0, rd, e, lat);
         chk("sw_rdata", rd, 0); chk("sw_err", e, 0);
         txn(d, 0, 3'b010, BASE + 4, 0, 0, rd, e, lat);
         chk("lw", rd, 32'hDEAD_BEEF); chk("lw_err", e, 0);
         txn(d, 0, 3'b000, BASE + 7, 0, 0, rd, e, lat); chk("lb", rd, 32'hFFFF_FFDE);
         txn(d, 0, 3'b100, BASE + 7, 0, 0, rd, e, lat); chk("lbu", rd, 32'h0000_00DE);
         txn(d, 0, 3'b001, BASE + 6, 0, 0, rd, e, lat); chk("lh", rd, 32'hFFFF_DEAD);
         txn(d, 0, 3'b101, BASE + 6, 0, 0, rd, e, lat); chk("lhu", rd, 32'h0000_DEAD);
         txn(d, 1, 3'b000, BASE + 5, 32'h0000_0011, 0, rd, e, lat);
         txn(d, 0, 3'b010, BASE + 4, 0, 0, rd, e, lat); chk("sb_lw", rd, 32'hDEAD_11EF);
         txn(d, 1, 3'b001, BASE + 5, 32'hFFFF_FFFF, 0, rd, e, lat); chk("sh_mis_err", e, 1);
         txn(d, 0, 3'b010, BASE + 4, 0, 0, rd, e, lat); chk("sh_mis_unchanged", rd, 32'hDEAD_11EF);
         txn(d, 0, 3'b010, 32'h7FFF_FFFC, 0, 0, rd, e, lat);
         chk("below_err", e, 1); chk("below_rdata", rd, 0);
         txn(d, 0, 3'b010, BASE + 4096, 0, 0, rd, e, lat); chk("above_err", e, 1);
         txn(d, 0, 3'b011, BASE + 4, 0, 0, rd, e, lat); chk("f3_011_err", e, 1);
         txn(d, 0, 3'b010, BASE + 4, 0, 5, rd, e, lat); chk("bp_lw", rd, 32'hDEAD_11EF);
         if (d == 0) begin
            @(negedge clk);
            req_valid[0] = 1; req_store[0] = 1; req_funct3[0] = 3'b010;
            req_addr[0] = BASE + 8; req_wdata[0] = 32'h1234_5678; rsp_ready[0] = 1;
            @(posedge clk);
            @(negedge clk);
            req_valid[0] = 0;
            chk("wait_req_ready", req_ready[0], 0);
            rst[0] = 1;
            @(posedge clk);
            @(negedge clk);
            rst[0] = 0; rsp_ready[0] = 0;
            chk("rstw_req_ready", req_ready[0], 1);
            chk("rstw_rsp_valid", rsp_valid[0], 0);
            txn(0, 0, 3'b010, BASE + 8, 0, 0, rd, e, lat);
            chk("rstw_not_written", rd != 32'h1234_5678, 1);
         end else begin
            @(negedge clk);
            req_valid[1] = 1; req_store[1] = 0; req_funct3[1] = 3'b010;
            req_addr[1] = BASE + 4; rsp_ready[1] = 0;
            @(posedge clk);
            @(negedge clk);
            req_valid[1] = 0;
            chk("resp_before_rst", rsp_valid[1], 1);
            rst[1] = 1; rsp_ready[1] = 1;
            @(posedge clk);
            @(negedge clk);
            rst[1] = 0; rsp_ready[1] = 0;
            chk("rstr_rsp_valid", rsp_valid[1], 0);
            chk("rstr_req_ready", req_ready[1], 1);
            txn(1, 1, 3'b010, BASE + 8, 32'h1234_5678, 0, rd, e, lat);
            txn(1, 0, 3'b010, BASE + 8, 0, 0, rd, e, lat); chk("l1_lw", rd, 32'h1234_5678);
         end
         for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            int r;
            r = $urandom % 8;
            a = r == 0 ? BASE + 4096 + ($urandom % 64) : r == 1 ? BASE - 1 - ($urandom % 64) : BASE + ($urandom % 64);
            txn(d, 1'($urandom), 3'($urandom), a, $urandom, ($urandom % 4 == 0) ? 1 + $urandom % 3 : 0, rd, e, lat);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
